// File: rtl/sha256_round_scheduler.sv
// -----------------------------------------------------------------------------
// sha256_round_scheduler
//
// Control FSM for one SHA-256 compression per 512-bit block. It kicks the
// message-expansion datapath, steps the round counter, strobes the working and
// hash register loads/updates, and hands the final digest to the consumer.
//
// Ports
//   CLK, RST       clock (rising edge) and synchronous active-high reset
//   block_valid    block source offers a padded 512-bit block
//   block_first    offered block starts a message (captured on accept)
//   block_last     offered block ends a message (captured on accept)
//   block_ready    scheduler can accept a block (IDLE only)
//   abort_in       cancel the current message, return to IDLE
//   exp_start      one-cycle start pulse to the message expansion
//   exp_round_in   round index reported back by the message expansion
//   load_iv        load H0..H7 with the IV (first block of a message)
//   load_work      copy H0..H7 into working registers a..h
//   round_en       compression round step enable
//   round_idx      current round / K-table address, 0 outside ROUND
//   hash_update    H[i] <= H[i] + working[i]
//   digest_valid   digest in H0..H7 is final
//   digest_ready   digest consumer accepts
//   busy           FSM is not IDLE
//   sched_err      sticky: expansion round index disagreed with round_idx
//   dbg_state      current FSM state, for checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. block_ready is high only in IDLE and does not depend on
// block_valid; digest_valid is held in DONE until digest_ready is sampled high.
// -----------------------------------------------------------------------------
module sha256_round_scheduler #(
    parameter int ROUNDS  = 64,
    parameter int ROUND_W = 7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               block_valid,
    input  logic               block_first,
    input  logic               block_last,
    output logic               block_ready,
    input  logic               abort_in,
    output logic               exp_start,
    input  logic [ROUND_W-1:0] exp_round_in,
    output logic               load_iv,
    output logic               load_work,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               hash_update,
    output logic               digest_valid,
    input  logic               digest_ready,
    output logic               busy,
    output logic               sched_err,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    // Registered Moore outputs
    logic               block_ready_q, exp_start_q, load_iv_q, load_work_q;
    logic               round_en_q, hash_update_q, digest_valid_q, busy_q;
    logic [ROUND_W-1:0] round_idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = err_q;

        // In ROUND the reported expansion round must track our own index.
        if (state_q == S_ROUND && exp_round_in != cnt_q) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    state_d = S_LOAD;
                    first_d = block_first;
                    last_d  = block_last;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // Leave at the last round so the counter never wraps.
                if (cnt_q == LAST_ROUND) begin
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + ROUND_W'(1);
                end
            end
            S_UPDATE: begin
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides everything, including an accept while IDLE.
        if (abort_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            err_q          <= 1'b0;
            block_ready_q  <= 1'b1;
            exp_start_q    <= 1'b0;
            load_iv_q      <= 1'b0;
            load_work_q    <= 1'b0;
            round_en_q     <= 1'b0;
            round_idx_q    <= '0;
            hash_update_q  <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            first_q        <= first_d;
            last_q         <= last_d;
            err_q          <= err_d;
            block_ready_q  <= (state_d == S_IDLE);
            exp_start_q    <= (state_d == S_LOAD);
            load_iv_q      <= (state_d == S_LOAD) && first_d;
            load_work_q    <= (state_d == S_LOAD);
            round_en_q     <= (state_d == S_ROUND);
            round_idx_q    <= (state_d == S_ROUND) ? cnt_d : '0;
            hash_update_q  <= (state_d == S_UPDATE);
            digest_valid_q <= (state_d == S_DONE);
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign block_ready  = block_ready_q;
    assign exp_start    = exp_start_q;
    assign load_iv      = load_iv_q;
    assign load_work    = load_work_q;
    assign round_en     = round_en_q;
    assign round_idx    = round_idx_q;
    assign hash_update  = hash_update_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;
    assign sched_err    = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sha256_round_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sha256_round_scheduler
//
// Directed bench for sha256_round_scheduler. Each entry in exp_q is
// {cycle, expected output vector}; the drivers push entries as they issue
// stimulus and the monitor pops and compares them at the matching cycle.
// -----------------------------------------------------------------------------
module tb_sha256_round_scheduler;

    localparam int ROUNDS  = 64;
    localparam int ROUND_W = 7;
    localparam int W       = 48;

    logic               clk;
    logic               RST;
    logic               block_valid;
    logic               block_first;
    logic               block_last;
    logic               block_ready;
    logic               abort_in;
    logic               exp_start;
    logic [ROUND_W-1:0] exp_round_in;
    logic               load_iv;
    logic               load_work;
    logic               round_en;
    logic [ROUND_W-1:0] round_idx;
    logic               hash_update;
    logic               digest_valid;
    logic               digest_ready;
    logic               busy;
    logic               sched_err;
    logic [2:0]         dbg_state;

    sha256_round_scheduler #(.ROUNDS(ROUNDS), .ROUND_W(ROUND_W)) dut (
        .CLK          (clk),
        .RST          (RST),
        .block_valid  (block_valid),
        .block_first  (block_first),
        .block_last   (block_last),
        .block_ready  (block_ready),
        .abort_in     (abort_in),
        .exp_start    (exp_start),
        .exp_round_in (exp_round_in),
        .load_iv      (load_iv),
        .load_work    (load_work),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .hash_update  (hash_update),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .sched_err    (sched_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic err_exp = 1'b0;

    // {block_ready, exp_start, load_iv, load_work, round_en, round_idx,
    //  hash_update, digest_valid, busy, sched_err}
    function automatic logic [15:0] mk(input logic br, input logic es, input logic iv,
                                       input logic lw, input logic re,
                                       input logic [6:0] idx, input logic hu,
                                       input logic dv, input logic bz, input logic er);
        return {br, es, iv, lw, re, idx, hu, dv, bz, er};
    endfunction

    function automatic logic [15:0] v_idle();
        return mk(1, 0, 0, 0, 0, 7'd0, 0, 0, 0, err_exp);
    endfunction
    function automatic logic [15:0] v_load(input logic iv);
        return mk(0, 1, iv, 1, 0, 7'd0, 0, 0, 1, err_exp);
    endfunction
    function automatic logic [15:0] v_round(input int k);
        return mk(0, 0, 0, 0, 1, 7'(k), 0, 0, 1, err_exp);
    endfunction
    function automatic logic [15:0] v_update();
        return mk(0, 0, 0, 0, 0, 7'd0, 1, 0, 1, err_exp);
    endfunction
    function automatic logic [15:0] v_done();
        return mk(0, 0, 0, 0, 0, 7'd0, 0, 1, 1, err_exp);
    endfunction

    task automatic push(input int at, input logic [15:0] v);
        exp_q.push_back({32'(at), v});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [15:0] act;
        logic [W-1:0] e;
        act = {block_ready, exp_start, load_iv, load_work, round_en, round_idx,
               hash_update, digest_valid, busy, sched_err};
        while (exp_q.size() > 0 && exp_q[0][47:16] <= 32'(cyc)) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (e[47:16] != 32'(cyc)) begin
                errors = errors + 1;
                $display("FAIL stale_entry cyc %0d entry for cyc %0d never compared", cyc, e[47:16]);
            end else if (act !== e[15:0]) begin
                errors = errors + 1;
                $display("FAIL outputs cyc %0d got %b required %b (br es iv lw re idx[7] hu dv bz er)",
                         cyc, act, e[15:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push(cyc, v_idle());
            tick();
        end
        push(cyc, v_idle());
    endtask

    // abort_rnd / rst_rnd / bad_rnd: round index at which to act, -1 for none.
    // rst_rnd == 100 asserts RST in the first DONE cycle instead.
    task automatic run_block(input logic first, input logic last, input int abort_rnd,
                             input int rst_rnd, input int bad_rnd, input int ready_lat);
        int waited;
        waited = 0;
        while (block_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        if (block_ready !== 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL block_ready_wait got %b required 1 within 200 cycles", block_ready);
            return;
        end
        push(cyc, v_idle());
        block_valid = 1'b1;
        block_first = first;
        block_last  = last;
        tick();
        block_valid = 1'b0;
        block_first = 1'b0;
        block_last  = 1'b0;
        push(cyc, v_load(first));
        for (int k = 0; k < ROUNDS; k++) begin
            tick();
            exp_round_in = (k == bad_rnd) ? 7'(k + 1) : 7'(k);
            push(cyc, v_round(k));
            if (k == bad_rnd) err_exp = 1'b1;
            if (k == abort_rnd) begin
                abort_in = 1'b1;
                tick();
                abort_in = 1'b0;
                exp_round_in = '0;
                push(cyc, v_idle());
                return;
            end
            if (k == rst_rnd) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                exp_round_in = '0;
                err_exp = 1'b0;
                push(cyc, v_idle());
                return;
            end
        end
        tick();
        exp_round_in = '0;
        push(cyc, v_update());
        tick();
        if (!last) begin
            push(cyc, v_idle());
            return;
        end
        if (rst_rnd == 100) begin
            push(cyc, v_done());
            RST = 1'b1;
            tick();
            RST = 1'b0;
            err_exp = 1'b0;
            push(cyc, v_idle());
            return;
        end
        for (int i = 0; i < ready_lat; i++) begin
            push(cyc, v_done());
            tick();
        end
        push(cyc, v_done());
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        push(cyc, v_idle());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST          = 1'b1;
        block_valid  = 1'b0;
        block_first  = 1'b0;
        block_last   = 1'b0;
        abort_in     = 1'b0;
        exp_round_in = '0;
        digest_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(cyc, v_idle());          // reset values
        RST = 1'b0;
        tick();
        idle_cycles(1);

        // single-block message
        run_block(1'b1, 1'b1, -1, -1, -1, 0);
        idle_cycles(1);

        // two-block message: IV only on the first, digest after the second
        run_block(1'b1, 1'b0, -1, -1, -1, 0);
        run_block(1'b0, 1'b1, -1, -1, -1, 0);

        // consumer stalls for 10 cycles in DONE
        run_block(1'b1, 1'b1, -1, -1, -1, 10);

        // abort mid-rounds: no hash_update, no digest_valid afterwards
        run_block(1'b1, 1'b1, 20, -1, -1, 0);
        idle_cycles(4);

        // abort while IDLE drops a simultaneous block offer
        push(cyc, v_idle());
        block_valid = 1'b1;
        block_first = 1'b1;
        block_last  = 1'b1;
        abort_in    = 1'b1;
        tick();
        block_valid = 1'b0;
        block_first = 1'b0;
        block_last  = 1'b0;
        abort_in    = 1'b0;
        idle_cycles(2);

        // expansion out of step at round 5: sticky error
        run_block(1'b1, 1'b1, -1, -1, 5, 0);
        idle_cycles(3);
        run_block(1'b1, 1'b1, -1, -1, -1, 0);

        // reset in the middle of the rounds clears the sticky error
        run_block(1'b1, 1'b1, -1, 40, -1, 0);
        idle_cycles(1);

        // reset while the digest is waiting
        run_block(1'b1, 1'b1, -1, 100, -1, 3);
        idle_cycles(1);

        // non-first block with no open message: processed without IV load
        run_block(1'b0, 1'b1, -1, -1, -1, 2);
        idle_cycles(2);

        tick();
        tick();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain got %0d pending entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL time_limit reached with %0d pending entries", exp_q.size());
        $fatal(1, "time limit");
    end

endmodule
